// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with frame-synchronous double buffering and inter-digit dead time.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic                load,
   output logic [DIGITS-1:0]   an,
   output logic [6:0]          seg,
   output logic                dp,
   output logic                frame_tick
);

   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned PRE_W = $clog2(SCAN_DIV);
   localparam int unsigned VAL_W = 4 * DIGITS;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

   logic [PRE_W-1:0]  prescaler;
   logic [IDX_W-1:0]  idx;
   logic [VAL_W-1:0]  pending;
   logic [DIGITS-1:0] pend_dp;
   logic              pend_flag;
   logic [VAL_W-1:0]  shadow;
   logic [DIGITS-1:0] shadow_dp;

   logic              step_c;
   logic              boundary_c;
   logic [3:0]        nib_c;
   logic              cur_dp_c;
   logic              blank_c;
   logic [6:0]        seg_c;
   logic [DIGITS-1:0] an_c;
`ifdef SEG7_LZB_EN
   logic              upper_zero_c;
`endif

   assign step_c     = (prescaler == PRE_LAST);
   assign boundary_c = step_c && (idx == IDX_LAST);

   // Prescaler and digit index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         idx       <= '0;
      end else if (step_c) begin
         prescaler <= '0;
         idx       <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
         prescaler <= prescaler + PRE_W'(1);
      end
   end

   // Pending/shadow buffers; shadow only changes on a frame boundary so a frame never tears
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= '0;
         pend_dp   <= '0;
         pend_flag <= 1'b0;
         shadow    <= '0;
         shadow_dp <= '0;
      end else if (load && boundary_c) begin
         pending   <= value;
         pend_dp   <= dp_in;
         pend_flag <= 1'b0;
         shadow    <= value;
         shadow_dp <= dp_in;
      end else begin
         if (load) begin
            pending   <= value;
            pend_dp   <= dp_in;
            pend_flag <= 1'b1;
         end else if (boundary_c && pend_flag) begin
            shadow    <= pending;
            shadow_dp <= pend_dp;
            pend_flag <= 1'b0;
         end
      end
   end

   // Select the current digit's nibble and decode it
   always_comb begin
      nib_c    = 4'h0;
      cur_dp_c = 1'b0;
      an_c     = '1;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (IDX_W'(k) == idx) begin
            nib_c    = shadow[4*k +: 4];
            cur_dp_c = shadow_dp[k];
            an_c[k]  = 1'b0;
         end
      end
`ifdef SEG7_LZB_EN
      upper_zero_c = 1'b1;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if ((IDX_W'(k) >= idx) && (shadow[4*k +: 4] != 4'h0)) upper_zero_c = 1'b0;
      end
      blank_c = (idx != '0) && upper_zero_c;
`else
      blank_c = 1'b0;
`endif
      case (nib_c)
         4'h0:    seg_c = 7'b1000000;
         4'h1:    seg_c = 7'b1111001;
         4'h2:    seg_c = 7'b0100100;
         4'h3:    seg_c = 7'b0110000;
         4'h4:    seg_c = 7'b0011001;
         4'h5:    seg_c = 7'b0010010;
         4'h6:    seg_c = 7'b0000010;
         4'h7:    seg_c = 7'b1111000;
         4'h8:    seg_c = 7'b0000000;
         4'h9:    seg_c = 7'b0010000;
         4'hA:    seg_c = 7'b0001000;
         4'hB:    seg_c = 7'b0000011;
         4'hC:    seg_c = 7'b1000110;
         4'hD:    seg_c = 7'b0100001;
         4'hE:    seg_c = 7'b0000110;
         default: seg_c = 7'b0001110;
      endcase
      if (blank_c) seg_c = 7'h7F;
   end

   // Registered outputs; the cycle after every step is a dead cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an         <= '1;
         seg        <= 7'h7F;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else if (step_c) begin
         an         <= '1;
         seg        <= 7'h7F;
         dp         <= 1'b1;
         frame_tick <= boundary_c;
      end else begin
         an         <= an_c;
         seg        <= seg_c;
         dp         <= ~cur_dp_c;
         frame_tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4).
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        load;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_tick;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] dig_seg [4];
   logic [3:0] dig_dp;
   logic [3:0] exp_an;
   logic [6:0] exp_seg;
   logic       exp_dp;
   logic       exp_ft;

   seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
      .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // Returns at the negedge of the dead cycle that carries frame_tick
   task automatic sync_frame(input string name);
      logic found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (frame_tick === 1'b1) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL %s sync: frame_tick got none want pulse within 40 clk", name);
      end
   endtask

   // Expected outputs for slot k (1..16) of a frame starting right after a frame_tick
   task automatic frame_expect(input int k);
      int d;
      d = k / 4;
      if (k % 4 == 0) begin
         exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
         exp_an = ~(4'b0001 << d); exp_seg = dig_seg[d]; exp_dp = ~dig_dp[d];
      end
      exp_ft = (k == 16);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0;
      repeat (3) @(negedge clk);
      n_cmp++; if (an !== 4'hF) begin n_bad++; $display("FAIL reset an got %b want 1111", an); end
      n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset seg got %b want 1111111", seg); end
      n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL reset dp got %b want 1", dp); end
      n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset frame_tick got %b want 0", frame_tick); end
      rst_n = 1'b1;
   endtask

   task automatic test_scan_zero();
      for (int e = 1; e <= 32; e++) begin
         @(negedge clk);
         if ((e - 1) % 4 == 3) begin
            exp_an = 4'hF; exp_seg = 7'h7F;
         end else begin
            exp_an = ~(4'b0001 << (((e - 1) / 4) % 4)); exp_seg = 7'b1000000;
         end
         exp_ft = (e % 16 == 0);
         n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL scan e=%0d an got %b want %b", e, an, exp_an); end
         n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL scan e=%0d seg got %b want %b", e, seg, exp_seg); end
         n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL scan e=%0d dp got %b want 1", e, dp); end
         n_cmp++; if (frame_tick !== exp_ft) begin n_bad++; $display("FAIL scan e=%0d frame_tick got %b want %b", e, frame_tick, exp_ft); end
      end
   endtask

   task automatic test_load_hex();
      sync_frame("load_hex");
      value = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      sync_frame("load_hex");
      dig_seg = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
      dig_dp  = 4'b0100;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         frame_expect(k);
         n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL load_hex k=%0d an got %b want %b", k, an, exp_an); end
         n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL load_hex k=%0d seg got %b want %b", k, seg, exp_seg); end
         n_cmp++; if (dp !== exp_dp) begin n_bad++; $display("FAIL load_hex k=%0d dp got %b want %b", k, dp, exp_dp); end
         n_cmp++; if (frame_tick !== exp_ft) begin n_bad++; $display("FAIL load_hex k=%0d frame_tick got %b want %b", k, frame_tick, exp_ft); end
      end
   endtask

   task automatic test_back_to_back();
      // Loads land mid digit 1; the whole current frame must still show 12AF
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         frame_expect(k);
         n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL b2b_old k=%0d seg got %b want %b", k, seg, exp_seg); end
         n_cmp++; if (dp !== exp_dp) begin n_bad++; $display("FAIL b2b_old k=%0d dp got %b want %b", k, dp, exp_dp); end
         if (k == 5) begin value = 16'h1111; dp_in = 4'b0000; load = 1'b1; end
         if (k == 6) value = 16'h2222;
         if (k == 7) load = 1'b0;
      end
      dig_seg = '{7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100};
      dig_dp  = 4'b0000;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         frame_expect(k);
         n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL b2b_new k=%0d an got %b want %b", k, an, exp_an); end
         n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL b2b_new k=%0d seg got %b want %b", k, seg, exp_seg); end
         n_cmp++; if (dp !== exp_dp) begin n_bad++; $display("FAIL b2b_new k=%0d dp got %b want %b", k, dp, exp_dp); end
      end
   endtask

   task automatic test_bypass();
      // Load is sampled on the same edge as the frame-boundary step
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         frame_expect(k);
         n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL bypass_pre k=%0d seg got %b want %b", k, seg, exp_seg); end
         n_cmp++; if (frame_tick !== exp_ft) begin n_bad++; $display("FAIL bypass_pre k=%0d frame_tick got %b want %b", k, frame_tick, exp_ft); end
         if (k == 15) begin value = 16'h0005; dp_in = 4'b0000; load = 1'b1; end
         if (k == 16) load = 1'b0;
      end
      dig_seg = '{7'b0010010, 7'b1000000, 7'b1000000, 7'b1000000};
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         frame_expect(k);
         n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL bypass k=%0d an got %b want %b", k, an, exp_an); end
         n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL bypass k=%0d seg got %b want %b", k, seg, exp_seg); end
      end
   endtask

   task automatic test_mid_reset();
      repeat (9) @(negedge clk);
      n_cmp++; if (an !== 4'b1011) begin n_bad++; $display("FAIL midrst_pre an got %b want 1011", an); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (an !== 4'hF) begin n_bad++; $display("FAIL midrst an got %b want 1111", an); end
      n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL midrst seg got %b want 1111111", seg); end
      n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL midrst dp got %b want 1", dp); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         if ((e - 1) % 4 == 3) begin
            exp_an = 4'hF; exp_seg = 7'h7F;
         end else begin
            exp_an = ~(4'b0001 << ((e - 1) / 4)); exp_seg = 7'b1000000;
         end
         n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL midrst_post e=%0d an got %b want %b", e, an, exp_an); end
         n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL midrst_post e=%0d seg got %b want %b", e, seg, exp_seg); end
      end
   endtask

   task automatic test_leading_zeros();
      value = 16'h0040; dp_in = 4'b0000; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      sync_frame("lz_0040");
`ifdef SEG7_LZB_EN
      dig_seg = '{7'b1000000, 7'b0011001, 7'h7F, 7'h7F};
`else
      dig_seg = '{7'b1000000, 7'b0011001, 7'b1000000, 7'b1000000};
`endif
      dig_dp = 4'b0000;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         frame_expect(k);
         n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL lz_0040 k=%0d an got %b want %b", k, an, exp_an); end
         n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL lz_0040 k=%0d seg got %b want %b", k, seg, exp_seg); end
      end
      value = 16'h0000; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      sync_frame("lz_0000");
`ifdef SEG7_LZB_EN
      dig_seg = '{7'b1000000, 7'h7F, 7'h7F, 7'h7F};
`else
      dig_seg = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
`endif
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         frame_expect(k);
         n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL lz_0000 k=%0d seg got %b want %b", k, seg, exp_seg); end
         n_cmp++; if (dp !== exp_dp) begin n_bad++; $display("FAIL lz_0000 k=%0d dp got %b want %b", k, dp, exp_dp); end
      end
   endtask

   initial begin
      test_reset();
      test_scan_zero();
      test_load_hex();
      test_back_to_back();
      test_bypass();
      test_mid_reset();
      test_leading_zeros();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
